// File: rtl/car_game_pkg.sv
// ============================================================================
// car_game_pkg
// Shared encodings for the car game: state codes, lane masks, LFSR taps and
// the obstacle spawn-pattern helper.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

package car_game_pkg;

    localparam logic [1:0] ST_IDLE  = 2'd0;
    localparam logic [1:0] ST_RUN   = 2'd1;
    localparam logic [1:0] ST_CRASH = 2'd2;

    localparam logic [2:0] LANE_L = 3'b100;
    localparam logic [2:0] LANE_C = 3'b010;
    localparam logic [2:0] LANE_R = 3'b001;

    localparam logic [7:0] LFSR_TAPS = 8'hB8;

    typedef enum logic [1:0] {
        S_IDLE  = ST_IDLE,
        S_RUN   = ST_RUN,
        S_CRASH = ST_CRASH
    } game_state_t;

    // A spawned row must always leave at least one lane open.
    function automatic logic [2:0] spawn_pattern(input logic [7:0] lfsr);
        logic [2:0] w_pat;
        w_pat = 3'b000;
        if (lfsr[7]) begin
            w_pat = lfsr[2:0];
            if (w_pat == (LANE_L | LANE_C | LANE_R))
                w_pat = LANE_L | LANE_C;
        end
        return w_pat;
    endfunction

endpackage

`default_nettype wire

// File: rtl/obstacle_scroller_lfsr8.sv
// ============================================================================
// lfsr8
// Free-running 8-bit Fibonacci LFSR, x^8+x^6+x^5+x^4+1, shifting left.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module lfsr8
    import car_game_pkg::*;
#(
    parameter logic [7:0] SEED = 8'hA5
) (
    input  logic       Clock,
    input  logic       Resetn,
    output logic [7:0] state
);

    logic [7:0] r_state;
    logic       w_feedback;

    assign w_feedback = ^(r_state & LFSR_TAPS);

    always_ff @(posedge Clock) begin
        if (!Resetn)
            r_state <= SEED;
        else
            r_state <= {r_state[6:0], w_feedback};
    end

    assign state = r_state;

endmodule

`default_nettype wire

// File: rtl/obstacle_scroller.sv
// ============================================================================
// obstacle_scroller
// Scrolling 3-lane obstacle grid with collision detection, scoring and the
// IDLE/RUN/CRASH game state machine. Optional macro:
// OBSTACLE_SCROLLER_SPAWN_GAP_EN forces an empty row after every non-empty one.
// Revision: 1.0 - initial release
// ============================================================================
`default_nettype none
`timescale 1ns/1ps

module obstacle_scroller
    import car_game_pkg::*;
#(
    parameter int         ROWS    = 8,
    parameter logic [7:0] SEED    = 8'hA5,
    parameter int         SCORE_W = 10
) (
    input  logic                 Clock,
    input  logic                 Resetn,
    input  logic                 start,
    input  logic                 tick,
    input  logic [2:0]           car_lane,
    output logic [3*ROWS-1:0]    grid,
    output logic [SCORE_W-1:0]   score,
    output logic                 running,
    output logic                 crashed,
    output logic                 scrolled
);

    localparam int           c_GRID_W    = 3 * ROWS;
    localparam logic [SCORE_W-1:0] c_SCORE_MAX = {SCORE_W{1'b1}};
    localparam logic [SCORE_W-1:0] c_SCORE_ONE = {{(SCORE_W-1){1'b0}}, 1'b1};

    game_state_t           r_state;
    logic [c_GRID_W-1:0]   r_grid;
    logic [SCORE_W-1:0]    r_score;
    logic                  r_running;
    logic                  r_crashed;
    logic                  r_scrolled;

    logic [7:0]            w_lfsr;
    logic [2:0]            w_bottom;
    logic                  w_collide;
    logic [2:0]            w_spawn;

    lfsr8 #(
        .SEED   (SEED)
    ) u_lfsr (
        .Clock  (Clock),
        .Resetn (Resetn),
        .state  (w_lfsr)
    );

    assign w_bottom  = r_grid[c_GRID_W-1 -: 3];
    assign w_collide = |(w_bottom & car_lane);

`ifdef OBSTACLE_SCROLLER_SPAWN_GAP_EN
    logic r_gap;

    assign w_spawn = r_gap ? 3'b000 : spawn_pattern(w_lfsr);

    always_ff @(posedge Clock) begin
        if (!Resetn)
            r_gap <= 1'b0;
        else if (r_state == S_CRASH && start)
            r_gap <= 1'b0;
        else if (r_state == S_RUN && !w_collide && tick)
            r_gap <= (w_spawn != 3'b000);
    end
`else
    assign w_spawn = spawn_pattern(w_lfsr);
`endif

    always_ff @(posedge Clock) begin
        if (!Resetn) begin
            r_state    <= S_IDLE;
            r_grid     <= '0;
            r_score    <= '0;
            r_running  <= 1'b0;
            r_crashed  <= 1'b0;
            r_scrolled <= 1'b0;
        end else begin
            r_scrolled <= 1'b0;
            case (r_state)
                S_IDLE: begin
                    r_grid <= '0;
                    if (start) begin
                        r_state   <= S_RUN;
                        r_running <= 1'b1;
                    end
                end
                S_RUN: begin
                    // A collision freezes the grid even if a tick arrives together with it.
                    if (w_collide) begin
                        r_state   <= S_CRASH;
                        r_running <= 1'b0;
                        r_crashed <= 1'b1;
                    end else if (tick) begin
                        r_grid     <= {r_grid[c_GRID_W-4:0], w_spawn};
                        r_scrolled <= 1'b1;
                        if (w_bottom != 3'b000 && r_score != c_SCORE_MAX)
                            r_score <= r_score + c_SCORE_ONE;
                    end
                end
                S_CRASH: begin
                    if (start) begin
                        r_state   <= S_RUN;
                        r_grid    <= '0;
                        r_score   <= '0;
                        r_running <= 1'b1;
                        r_crashed <= 1'b0;
                    end
                end
                default: begin
                    r_state   <= S_IDLE;
                    r_grid    <= '0;
                    r_score   <= '0;
                    r_running <= 1'b0;
                    r_crashed <= 1'b0;
                end
            endcase
        end
    end

    assign grid     = r_grid;
    assign score    = r_score;
    assign running  = r_running;
    assign crashed  = r_crashed;
    assign scrolled = r_scrolled;

endmodule

`default_nettype wire

// File: doc/obstacle_scroller.md
Name: obstacle_scroller

Overview:
- Downstream consumer of the speed-tick generator's single-cycle enable pulse (half/quarter/eighth-second tick).
- Holds a ROWS x 3-lane obstacle grid. On each tick it scrolls the grid down one row and spawns a pseudo-random row at the top.
- Checks the bottom row against the car's lane every cycle, keeps the score, and owns the IDLE/RUN/CRASH game-state machine that feeds the VGA draw logic.

Parameters:
- ROWS, 8, grid depth in rows; row 0 is the top, row ROWS-1 is the car row; legal range 4..16.
- SEED, 8'hA5, LFSR reset value; must be nonzero.
- SCORE_W, 10, score counter width.

Ports:
- Clock  in  1  system clock, 50 MHz.
- Resetn  in  1  synchronous, active-low reset.
- start  in  1  level; starts the game from IDLE, restarts it from CRASH.
- tick  in  1  single-cycle scroll pulse from the speed stage.
- car_lane  in  3  one-hot car lane ([2]=left, [1]=centre, [0]=right); 000 means no car.
- grid  out  3*ROWS  row r occupies bits [3r+2:3r]; 1 = obstacle.
- score  out  SCORE_W  rows survived.
- running  out  1  high in RUN.
- crashed  out  1  high in CRASH.
- scrolled  out  1  one-cycle pulse, registered, on every accepted scroll.

Behaviour:
- Reset (Resetn=0 at a Clock edge) has priority over every other input and applies mid-operation too:
  - state=IDLE, grid=0, score=0, scrolled=0, running=0, crashed=0, LFSR=SEED.
- LFSR: 8-bit Fibonacci, polynomial x^8+x^6+x^5+x^4+1, shifts left every Clock in every state (free-running).
- Spawn pattern, taken from the current LFSR value at the scroll edge:
  - lfsr[7]=0 -> 000.
  - Otherwise lfsr[2:0]; if that equals 111, use 110 instead.
  - A row never blocks all three lanes.
- States and transitions:
  - IDLE: grid held at 0. start=1 -> RUN. tick ignored.
  - RUN, on a tick:
    - grid[r] <= grid[r-1] for r=1..ROWS-1; grid[0] <= spawn pattern.
    - If the pre-shift bottom row was nonzero, score increments and saturates at all-ones (no wrap).
    - scrolled=1 on the following cycle.
  - RUN, collision check every cycle: (grid[ROWS-1] & car_lane) != 0 -> CRASH at the next edge. The grid is frozen from that edge on.
  - CRASH: grid and score frozen; tick ignored. start=1 -> grid=0, score=0, then RUN. The LFSR is not reseeded.
- Simultaneous events:
  - Collision and tick in the same RUN cycle: the crash wins; no scroll, no score increment, scrolled stays 0.
  - start while in RUN: ignored.
  - start and tick together in IDLE: go to RUN only; the first scroll happens on the next tick.
- car_lane with more than one bit set is treated bitwise; any overlap is a collision.
- Latency:
  - tick to grid update: 1 edge.
  - Collision condition to crashed=1: 1 edge.
  - Outputs are all registered.

Optional Feature:
- Macro: OBSTACLE_SCROLLER_SPAWN_GAP_EN.
- Defined: a 1-bit flag forces the spawn pattern to 000 on the scroll immediately after any nonzero spawn. Two consecutive grid rows are then never both nonzero, which guarantees a reachable path. The flag resets to 0 and is also cleared on restart.
- Undefined: spawn pattern exactly as specified in Behaviour; no flag register exists.

Decomposition:
- Shared package car_game_pkg holds:
  - state encoding localparams ST_IDLE=2'd0, ST_RUN=2'd1, ST_CRASH=2'd2;
  - LANE_L/LANE_C/LANE_R one-hot constants;
  - the LFSR tap mask 8'hB8.
- One sub-module, lfsr8 (Clock, Resetn, seed parameter, 8-bit state output). It is reused later by the car spawn logic.
- Grid shift, FSM and scoring stay in this module.

Test Plan:
- Reset mid-RUN after 5 ticks: assert Resetn=0 for one edge -> grid=0, score=0, running=0, crashed=0, LFSR=8'hA5 next cycle.
- IDLE, pulse tick 3 times -> grid stays 0, scrolled never asserts; start=1 -> running=1 one edge later.
- RUN, car_lane=000, 40 ticks, SEED=8'hA5 -> each row matches a bench LFSR model one scroll later; no row is 111; score equals the count of nonzero rows that left the bottom; crashed stays 0.
- RUN with ROWS=4, car_lane follows the model's first nonzero bottom lane -> crashed=1 exactly one edge after overlap; further ticks leave grid and score unchanged.
- Collision and tick in the same cycle -> CRASH, grid unchanged, score unchanged, scrolled=0; then start=1 -> grid=0, score=0, running=1.
- SCORE_W=2, car_lane=000, tick until 5 nonzero rows exit -> score saturates at 3; with OBSTACLE_SCROLLER_SPAWN_GAP_EN, no two adjacent rows are ever both nonzero over 200 ticks.
